ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch stage for the mini CPU, the initiator side of the instruction-memory interface. Owns the PC register, drives the word address into the combinational instruction memory, registers the returned instruction into the IF/ID pipeline register, and resolves PC-relative jumps (J, JAL) early. It accepts branch and JR redirects from execute, supports pipeline stalls, and halts itself after a run of NOOPs.

## Interface
- PC_W, 32, PC and address width; word addressing, so one instruction per address
- RESET_PC, 0, PC value loaded on reset
- NOOP_LIMIT, 4, consecutive valid all-zero fetches that trigger halt; range 1..15

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_pc  out  PC_W  address to instruction memory; always equals the PC register
- imem_instr  in  32  instruction returned combinationally for imem_pc
- stall  in  1  hold the PC and IF/ID register
- redirect_valid  in  1  execute-resolved taken branch or JR
- redirect_target  in  PC_W  new PC when redirect_valid=1
- if_valid  out  1  IF/ID register holds a real instruction
- if_instr  out  32  registered instruction
- if_pc  out  PC_W  address of if_instr
- if_pc_plus1  out  PC_W  if_pc+1, used as the link value for JAL
- halted  out  1  fetch halted on the NOOP run

## Operation
- States: RUN, HALTED. Reset puts the block in RUN. HALTED is left only through rst.
- Per-edge priority in RUN is redirect > stall > early jump > sequential.
- Redirect:
  - pc ← redirect_target.
  - if_valid ← 0, which squashes the wrong-path instruction.
  - NOOP counter ← 0.
  - Overrides stall.
- Stall, with no redirect: pc, if_valid, if_instr, if_pc, if_pc_plus1 and the counter all hold.
- Normal fetch:
  - if_instr ← imem_instr, if_pc ← pc, if_pc_plus1 ← pc+1, if_valid ← 1.
  - Next PC:
    - If imem_instr[31:26] = 000001 (J) or 000010 (JAL): pc ← pc+1+sext(imem_instr[15:0]).
    - Otherwise: pc ← pc+1.
  - The J/JAL instruction is still passed downstream with if_valid=1.
  - Opcode 000011 (JR) is not resolved here. Execute returns it through redirect.
- NOOP counter:
  - On a normal fetch of imem_instr = 0: counter+1, saturating at NOOP_LIMIT.
  - On a normal fetch of any nonzero instruction: counter ← 0.
  - When the increment reaches NOOP_LIMIT: state ← HALTED at that edge.
- HALTED:
  - pc holds, if_valid=0, halted=1.
  - if_instr and if_pc hold their last values.
  - stall and redirect are ignored.
- Arithmetic: all PC arithmetic is modulo 2^PC_W. sext extends 16 bits to PC_W.

## Timing
- Reset values, applied asynchronously:
  - pc = RESET_PC, so imem_pc = RESET_PC immediately.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus1=0, halted=0, counter=0, state=RUN.
- Latency: the instruction at address A appears on if_instr one edge after imem_pc=A.
- Throughput is one instruction per cycle when not stalled.
- Early jump costs no bubble. The target is fetched on the edge after the jump is fetched.
- Redirect costs exactly one bubble. if_valid=0 for the cycle after the redirect edge, and the target instruction is registered on the following edge.
- Redirect and stall in the same cycle: the redirect takes effect, and if_valid ← 0 even though stall was high.
- Redirect in the same cycle the fetched word is a J: the redirect wins and the jump target is discarded.
- Wrap: pc = 2^PC_W−1 fetching a non-jump word gives next pc = 0.
- Reset asserted mid-operation: every output returns to its reset value without waiting for a clock edge. Fetch resumes at RESET_PC on the first edge after deassertion.
- halted rises on the same edge that registers the NOOP_LIMIT-th NOOP. That NOOP is still presented with if_valid=1 for one cycle, then if_valid=0.

## Test plan
- Reset, then run 3 cycles with memory returning words at addresses 0,1,2 → imem_pc steps 0,1,2,3; if_pc steps 0,1,2 with if_valid=1; first if_valid=1 is one edge after reset deasserts.
- Fetch J with imm 0x0002 at pc=18 (0x04000002) → next imem_pc=21; if_instr=0x04000002, if_pc=18; no bubble. Also JAL imm 0x0007 at pc=2 → next imem_pc=10 and if_pc_plus1=3.
- Redirect to target 10 while pc=13 → next imem_pc=10 and if_valid=0 for one cycle; the address-10 word appears on the following edge with if_pc=10.
- Hold stall for 3 cycles at pc=7 → imem_pc, if_instr and if_pc frozen; then stall plus redirect to 0x20 in one cycle → imem_pc=0x20 and if_valid=0.
- Memory returns 0 from pc=23 onward with NOOP_LIMIT=4 → halted=1 on the edge registering pc=26; pc stays 27; if_valid=0 afterwards; a later redirect is ignored. Then NOOP,NOOP,nonzero,NOOP,NOOP,NOOP → no halt, because the counter reset.
- pc=0xFFFFFFFF with a non-jump word → next imem_pc=0. Assert rst asynchronously mid-stream → imem_pc=RESET_PC and if_valid=0 before the next edge.

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, IF/ID register, early jumps, NOOP-run halt
module ifetch_unit #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              NOOP_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_pc,
    input  logic [31:0]     imem_instr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_pc_plus1,
    output logic            halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // NOOP_LIMIT is at most 15, so four counter bits always suffice
    localparam logic [3:0] NOOP_LIM = 4'(NOOP_LIMIT);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_d;
    logic            if_valid_q;
    logic [31:0]     if_instr_q;
    logic [PC_W-1:0] if_pc_q;
    logic [PC_W-1:0] if_pc_plus1_q;
    logic            halted_q;
    logic [3:0]      noop_cnt_q;
    logic [3:0]      noop_cnt_inc;
    logic            is_jump;
    logic            is_noop;
    logic [PC_W-1:0] jump_offset;

    // Next PC for a normal fetch: J/JAL resolve here, everything else falls through
    always_comb begin
        pc_plus1     = pc_q + PC_W'(1);
        is_jump      = (imem_instr[31:26] == 6'b000001) || (imem_instr[31:26] == 6'b000010);
        is_noop      = (imem_instr == 32'd0);
        jump_offset  = {{(PC_W-16){imem_instr[15]}}, imem_instr[15:0]};
        noop_cnt_inc = noop_cnt_q + 4'd1;
        pc_d         = pc_plus1;
        if (is_jump) begin
            pc_d = pc_plus1 + jump_offset;
        end
    end

    // Fetch FSM: redirect > stall > fetch in RUN; HALTED freezes everything until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= '0;
            if_pc_plus1_q <= '0;
            halted_q      <= 1'b0;
            noop_cnt_q    <= 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_target;
                        if_valid_q <= 1'b0;
                        noop_cnt_q <= 4'd0;
                    end else if (!stall) begin
                        pc_q          <= pc_d;
                        if_instr_q    <= imem_instr;
                        if_pc_q       <= pc_q;
                        if_pc_plus1_q <= pc_plus1;
                        if_valid_q    <= 1'b1;
                        if (is_noop) begin
                            if (noop_cnt_inc >= NOOP_LIM) begin
                                noop_cnt_q <= NOOP_LIM;
                                halted_q   <= 1'b1;
                                state_q    <= ST_HALTED;
                            end else begin
                                noop_cnt_q <= noop_cnt_inc;
                            end
                        end else begin
                            noop_cnt_q <= 4'd0;
                        end
                    end
                end
                ST_HALTED: begin
                    // The final NOOP gets its one valid cycle, then the stage goes quiet
                    if_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign imem_pc     = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus1 = if_pc_plus1_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus1;
    logic        halted;

    int n_cmp;
    int n_err;

    ifetch_unit #(.PC_W(32), .RESET_PC(32'd0), .NOOP_LIMIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_pc         (imem_pc),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus1     (if_pc_plus1),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        step();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        imem_instr = 32'h0000_0011;
        #1;
        chk("rst_pc", imem_pc, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_ifpc", if_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        step();
        chk("rst_hold_pc", imem_pc, 32'd0);
        rst = 1'b0;

        // sequential fetch 0,1,2
        imem_instr = 32'h0000_0011;
        step();
        chk("seq0_valid", {31'd0, if_valid}, 32'd1);
        chk("seq0_ifpc", if_pc, 32'd0);
        chk("seq0_instr", if_instr, 32'h0000_0011);
        chk("seq0_pc", imem_pc, 32'd1);
        imem_instr = 32'h0000_0022;
        step();
        chk("seq1_ifpc", if_pc, 32'd1);
        chk("seq1_pc", imem_pc, 32'd2);
        imem_instr = 32'h0000_0033;
        step();
        chk("seq2_ifpc", if_pc, 32'd2);
        chk("seq2_plus1", if_pc_plus1, 32'd3);
        chk("seq2_pc", imem_pc, 32'd3);

        // J imm 2 at pc 18
        redir(32'd18);
        chk("rd18_pc", imem_pc, 32'd18);
        chk("rd18_valid", {31'd0, if_valid}, 32'd0);
        imem_instr = 32'h0400_0002;
        step();
        chk("j_pc", imem_pc, 32'd21);
        chk("j_instr", if_instr, 32'h0400_0002);
        chk("j_ifpc", if_pc, 32'd18);
        chk("j_valid", {31'd0, if_valid}, 32'd1);
        imem_instr = 32'h0000_0021;
        step();
        chk("jt_ifpc", if_pc, 32'd21);
        chk("jt_valid", {31'd0, if_valid}, 32'd1);

        // JAL imm 7 at pc 2
        redir(32'd2);
        imem_instr = 32'h0800_0007;
        step();
        chk("jal_pc", imem_pc, 32'd10);
        chk("jal_plus1", if_pc_plus1, 32'd3);

        // redirect to 10 while pc=13
        redir(32'd13);
        imem_instr = 32'h0000_0013;
        redir(32'd10);
        chk("rd10_pc", imem_pc, 32'd10);
        chk("rd10_valid", {31'd0, if_valid}, 32'd0);
        imem_instr = 32'h0000_AAAA;
        step();
        chk("rd10_ifpc", if_pc, 32'd10);
        chk("rd10_instr", if_instr, 32'h0000_AAAA);
        chk("rd10_valid2", {31'd0, if_valid}, 32'd1);

        // redirect wins over a J fetched in the same cycle
        imem_instr = 32'h0400_0005;
        redir(32'd40);
        chk("rdj_pc", imem_pc, 32'd40);
        chk("rdj_valid", {31'd0, if_valid}, 32'd0);

        // stall around pc 7
        redir(32'd7);
        imem_instr = 32'h0000_0077;
        step();
        chk("st_pre_pc", imem_pc, 32'd8);
        stall = 1'b1;
        imem_instr = 32'h0000_0088;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", imem_pc, 32'd8);
            chk("st_instr", if_instr, 32'h0000_0077);
            chk("st_ifpc", if_pc, 32'd7);
            chk("st_valid", {31'd0, if_valid}, 32'd1);
        end
        redir(32'h20);
        stall = 1'b0;
        chk("strd_pc", imem_pc, 32'h20);
        chk("strd_valid", {31'd0, if_valid}, 32'd0);

        // NOOP,NOOP,nonzero,NOOP,NOOP,NOOP: counter clears, no halt
        imem_instr = 32'd0;          step();
        imem_instr = 32'd0;          step();
        imem_instr = 32'h0000_0005;  step();
        imem_instr = 32'd0;          step();
        imem_instr = 32'd0;          step();
        imem_instr = 32'd0;          step();
        chk("nohalt", {31'd0, halted}, 32'd0);
        chk("nohalt_pc", imem_pc, 32'h26);

        // wrap
        redir(32'hFFFF_FFFF);
        imem_instr = 32'h0000_0005;
        step();
        chk("wrap_pc", imem_pc, 32'd0);
        chk("wrap_plus1", if_pc_plus1, 32'd0);

        // NOOP run from 23
        redir(32'd23);
        imem_instr = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("run_halted", {31'd0, halted}, 32'd0);
        end
        step();
        chk("halt_rise", {31'd0, halted}, 32'd1);
        chk("halt_ifpc", if_pc, 32'd26);
        chk("halt_valid", {31'd0, if_valid}, 32'd1);
        chk("halt_pc", imem_pc, 32'd27);
        step();
        chk("halt_valid2", {31'd0, if_valid}, 32'd0);
        chk("halt_pc2", imem_pc, 32'd27);
        chk("halt_ifpc2", if_pc, 32'd26);
        redir(32'd5);
        chk("halt_rd_pc", imem_pc, 32'd27);
        chk("halt_rd_h", {31'd0, halted}, 32'd1);

        // asynchronous reset mid-stream
        #1;
        rst = 1'b1;
        #1;
        chk("arst_pc", imem_pc, 32'd0);
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_ifpc", if_pc, 32'd0);
        step();
        rst = 1'b0;
        imem_instr = 32'h0000_0099;
        step();
        chk("resume_ifpc", if_pc, 32'd0);
        chk("resume_instr", if_instr, 32'h0000_0099);
        chk("resume_pc", imem_pc, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
